// File: rtl/load_store_unit.sv
// Load/store unit: sizes and aligns byte/half/word accesses onto a word-wide
// DataMemory port, using read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [31:0]           mem_read_data
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, unsigned_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           word_q;

  logic        accept_c;
  logic        req_bad_c;
  logic [7:0]  byte_lane_c;
  logic [15:0] half_lane_c;
  logic [31:0] load_ext_c;
  logic [31:0] merged_c;

  assign accept_c = req_valid && (state_q == IDLE);

  // Illegal size or misaligned address on the incoming request
  always_comb begin
    req_bad_c = 1'b0;
    case (req_size)
      SIZE_BYTE: req_bad_c = 1'b0;
      SIZE_HALF: req_bad_c = req_addr[0];
      SIZE_WORD: req_bad_c = (req_addr[1:0] != 2'b00);
      default:   req_bad_c = 1'b1;
    endcase
  end

  // State register and request/readback capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        we_q       <= req_we;
        unsigned_q <= req_unsigned;
        err_q      <= req_bad_c;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
      end
      if (state_q == READ) begin
        word_q <= mem_read_data;
      end
    end
  end

  // Next-state: errors skip memory, word stores skip the readback
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (req_bad_c)                            state_d = RESP;
          else if (req_we && req_size == SIZE_WORD) state_d = WRITE;
          else                                      state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Little-endian lane extraction from the captured word
  always_comb begin
    byte_lane_c = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_lane_c = word_q[7:0];
      2'd1:    byte_lane_c = word_q[15:8];
      2'd2:    byte_lane_c = word_q[23:16];
      default: byte_lane_c = word_q[31:24];
    endcase
    half_lane_c = addr_q[1] ? word_q[31:16] : word_q[15:0];
  end

  // Load extension and store lane merge
  always_comb begin
    load_ext_c = word_q;
    merged_c   = wdata_q;
    case (size_q)
      SIZE_BYTE: begin
        load_ext_c = unsigned_q ? {24'h000000, byte_lane_c}
                                : {{24{byte_lane_c[7]}}, byte_lane_c};
        merged_c   = word_q;
        case (addr_q[1:0])
          2'd0:    merged_c[7:0]   = wdata_q[7:0];
          2'd1:    merged_c[15:8]  = wdata_q[7:0];
          2'd2:    merged_c[23:16] = wdata_q[7:0];
          default: merged_c[31:24] = wdata_q[7:0];
        endcase
      end
      SIZE_HALF: begin
        load_ext_c = unsigned_q ? {16'h0000, half_lane_c}
                                : {{16{half_lane_c[15]}}, half_lane_c};
        merged_c   = addr_q[1] ? {wdata_q[15:0], word_q[15:0]}
                               : {word_q[31:16], wdata_q[15:0]};
      end
      default: begin
        load_ext_c = word_q;
        merged_c   = wdata_q;
      end
    endcase
  end

  // Outputs decoded from the state register and latched request
  always_comb begin
    req_ready        = (state_q == IDLE);
    resp_valid       = (state_q == RESP);
    resp_err         = (state_q == RESP) && err_q;
    resp_rdata       = 32'h0;
    mem_read_enable  = (state_q == READ);
    mem_write_enable = (state_q == WRITE);
    mem_write_data   = 32'h0;
    mem_address      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    if (state_q == RESP && !we_q && !err_q) resp_rdata = load_ext_c;
    if (state_q == WRITE)                   mem_write_data = merged_c;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses against a word memory model,
// scoreboarded responses, plus reset-in-RMW and back-to-back sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_read_data;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // DataMemory model: combinational read, write at rising edge
  logic [31:0] mem [0:15];
  assign mem_read_data = mem[mem_address[5:2]];
  always @(posedge clk) if (mem_write_enable) mem[mem_address[5:2]] <= mem_write_data;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_mem;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   quiet_bad = 0;
  int   excl_bad  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Per-cycle invariants: idle response outputs quiet, enables exclusive
  task automatic sample_quiet();
    if (!resp_valid && (resp_rdata !== 32'h0 || resp_err !== 1'b0)) quiet_bad++;
    if (!mem_write_enable && mem_write_data !== 32'h0) quiet_bad++;
    if (mem_read_enable && mem_write_enable) excl_bad++;
  endtask

  task automatic check_resp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: unexpected response rdata 0x%08h err %0b, expected none", name, resp_rdata, resp_err);
    end else begin
      e = sb.pop_front();
      chk({name, "_rdata"}, resp_rdata, e.rdata);
      chk({name, "_err"}, 32'(resp_err), 32'(e.err));
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic do_req(input vec_t v, input int idx);
    int  rd, wr, lat;
    bit  done;
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    req_valid = 1'b1;
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF);
    rd = 0; wr = 0; lat = -1; done = 1'b0;
    for (int n = 1; n <= 8 && !done; n++) begin
      if (n > 1) @(negedge clk);
      sample_quiet();
      rd += int'(mem_read_enable);
      wr += int'(mem_write_enable);
      if (resp_valid) begin
        check_resp(nm);
        lat  = n;
        done = 1'b1;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, "_reads"},   32'(rd),  32'(v.exp_rd));
    chk({nm, "_writes"},  32'(wr),  32'(v.exp_wr));
    chk({nm, "_memword"}, mem[v.addr[5:2]], v.exp_mem);
  endtask

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    int wr_after_rst;
    int na, nr;
    int acc_cyc[2];
    int resp_cyc[2];
    bit switched;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    //           we    size   uns   addr   wdata         rdata         err lat rd wr mem
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0, 32'hABCDEF01, 32'h00000000, 1'b0, 2, 0, 1, 32'hABCDEF01};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'hABCDEF01, 1'b0, 2, 1, 0, 32'hABCDEF01};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h2, 32'h12345655, 32'h00000000, 1'b0, 3, 1, 1, 32'hAB55EF01};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h3, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 1, 0, 32'hAB55EF01};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h3, 32'h0,        32'h000000AB, 1'b0, 2, 1, 0, 32'hAB55EF01};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0, 32'h0,        32'hFFFFEF01, 1'b0, 2, 1, 0, 32'hAB55EF01};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h2, 32'h0,        32'h0000AB55, 1'b0, 2, 1, 0, 32'hAB55EF01};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h2, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'hAB55EF01};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h0, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'hAB55EF01};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h1, 32'h0000FFFF, 32'h00000000, 1'b1, 1, 0, 0, 32'hAB55EF01};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h1, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'hAB55EF01};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h6, 32'h7777BEEF, 32'h00000000, 1'b0, 3, 1, 1, 32'hBEEF0000};
    vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h6, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'hBEEF0000};
    vecs[13] = '{1'b1, 2'b00, 1'b0, 32'h4, 32'hFFFFFF80, 32'h00000000, 1'b0, 3, 1, 1, 32'hBEEF0080};
    vecs[14] = '{1'b0, 2'b00, 1'b0, 32'h4, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 32'hBEEF0080};
    vecs[15] = '{1'b0, 2'b01, 1'b1, 32'h4, 32'h0,        32'h00000080, 1'b0, 2, 1, 0, 32'hBEEF0080};
    vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 0, 1, 32'hCAFEF00D};
    vecs[17] = '{1'b0, 2'b00, 1'b1, 32'h9, 32'h0,        32'h000000F0, 1'b0, 2, 1, 0, 32'hCAFEF00D};
    vecs[18] = '{1'b1, 2'b10, 1'b0, 32'hA, 32'h11111111, 32'h00000000, 1'b1, 1, 0, 0, 32'hCAFEF00D};

    rst_n = 1'b0;
    req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",      32'(req_ready),        32'd1);
    chk("reset_resp_valid", 32'(resp_valid),       32'd0);
    chk("reset_resp_err",   32'(resp_err),         32'd0);
    chk("reset_resp_rdata", resp_rdata,            32'h0);
    chk("reset_enables",    32'({mem_read_enable, mem_write_enable}), 32'd0);
    chk("reset_mem_addr",   mem_address,           32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) do_req(vecs[i], i);

    // Reset during the READ cycle of a half store abandons it
    @(negedge clk);
    drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h00001234);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_in_read", 32'(mem_read_enable), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_ready",      32'(req_ready),  32'd1);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_enables",    32'({mem_read_enable, mem_write_enable}), 32'd0);
    chk("rst_mid_mem_addr",   mem_address,     32'h0);
    wr_after_rst = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      sample_quiet();
      wr_after_rst += int'(mem_write_enable) + int'(resp_valid);
    end
    chk("rst_mid_no_activity", 32'(wr_after_rst), 32'd0);
    chk("rst_mid_mem_unchanged", mem[0], 32'hAB55EF01);

    // Back-to-back loads with req_valid held high
    na = 0; nr = 0; switched = 1'b0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; resp_cyc[0] = -1; resp_cyc[1] = -1;
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    req_valid = 1'b1;
    sb.push_back('{32'hBEEF0080, 1'b0});
    for (int n = 0; n < 16 && nr < 2; n++) begin
      if (n > 0) @(negedge clk);
      if (na == 1 && !switched) begin
        drive(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
        sb.push_back('{32'hFFFFFFAB, 1'b0});
        switched = 1'b1;
      end
      if (na >= 2) req_valid = 1'b0;
      sample_quiet();
      if (resp_valid) begin
        check_resp($sformatf("b2b_resp%0d", nr));
        if (nr < 2) resp_cyc[nr] = n;
        nr++;
      end
      if (req_valid && req_ready) begin
        if (na < 2) acc_cyc[na] = n;
        na++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts",    32'(na), 32'd2);
    chk("b2b_responses",  32'(nr), 32'd2);
    chk("b2b_first_lat",  32'(resp_cyc[0] - acc_cyc[0]), 32'd2);
    chk("b2b_second_acc", 32'(acc_cyc[1]), 32'(resp_cyc[0] + 1));

    chk("sb_drained",      32'(sb.size()), 32'd0);
    chk("quiet_outputs",   32'(quiet_bad), 32'd0);
    chk("enable_exclusive", 32'(excl_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, request and memory byte-address width.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  access request present.
REQ-006 req_ready  out  1  unit idle, request accepted when req_valid & req_ready at rising edge.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  loads zero-extend when 1, sign-extend when 0.
REQ-010 req_addr  in  ADDR_WIDTH  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-014 resp_err  out  1  misaligned or illegal-size request, valid with resp_valid.
REQ-015 mem_address  out  ADDR_WIDTH  word-aligned address to DataMemory, {addr[ADDR_WIDTH-1:2],2'b00}.
REQ-016 mem_write_data  out  32  full word to DataMemory.
REQ-017 mem_write_enable  out  1  DataMemory commits mem_write_data at rising edge while high.
REQ-018 mem_read_enable  out  1  DataMemory read strobe.
REQ-019 mem_read_data  in  32  DataMemory word, valid combinationally in the cycle mem_read_enable is high.

Function
REQ-020 FSM states SHALL be IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-021 On acceptance SHALL latch we, size, unsigned, addr, wdata; inputs ignored outside IDLE.
REQ-022 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: IDLE->RESP, resp_err=1, no memory enable ever asserted.
REQ-023 Load: IDLE->READ->RESP; READ drives mem_read_enable=1 and captures mem_read_data at the READ-exit edge; resp_valid high in the 2nd cycle after acceptance.
REQ-024 Word store: IDLE->WRITE->RESP; WRITE drives mem_write_enable=1, mem_write_data=wdata; resp_valid in 2nd cycle after acceptance.
REQ-025 Byte/half store: IDLE->READ->WRITE->RESP (read-modify-write); WRITE data = captured word with the addressed lane(s) replaced; resp_valid in 3rd cycle after acceptance.
REQ-026 Lane selection little-endian: byte lane addr[1:0], half lane addr[1] (bits [15:0] or [31:16]).
REQ-027 Load extension: byte/half sign- or zero-extended per latched unsigned; word passed unchanged.
REQ-028 RESP lasts exactly one cycle, then IDLE; a new request may be accepted in the cycle after RESP.
REQ-029 mem_write_enable high only in WRITE, mem_read_enable high only in READ; never both.
REQ-030 mem_address held from latched address in all states; mem_write_data = 0 outside WRITE.
REQ-031 resp_rdata, resp_err held 0 whenever resp_valid = 0.

Reset
REQ-032 rst_n low at a rising edge SHALL force IDLE, clear all latched registers; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_* enables=0, mem_address=0 in the following cycle.
REQ-033 Reset during READ of an RMW store SHALL abandon it with no memory write; reset in WRITE cycle takes precedence only for subsequent cycles (write at that edge commits).

Verification
REQ-034 Word store 0xABCDEF01 @0x0, then word load @0x0 -> one mem_write_enable cycle; resp_rdata=0xABCDEF01, resp_err=0.
REQ-035 Byte store 0x55 @0x2 over 0xABCDEF01 -> READ then WRITE; memory word 0xAB55EF01; resp_valid 3 cycles after acceptance.
REQ-036 Loads of 0xAB55EF01: signed byte @0x3 -> 0xFFFFFFAB; unsigned byte @0x3 -> 0x000000AB; signed half @0x0 -> 0xFFFFEF01; unsigned half @0x2 -> 0x0000AB55.
REQ-037 Word load @0x2 and size 11 @0x0 -> resp_valid next cycle after acceptance, resp_err=1, resp_rdata=0, no memory enable.
REQ-038 rst_n low in READ of half store 0x1234 @0x0 over 0xAB55EF01 -> memory unchanged, req_ready=1 after reset.
REQ-039 req_valid held high for two loads -> second accepted only in IDLE after first RESP; exactly one resp_valid per request.
